// File: rtl/trigger_burst_reader_pkg.sv
// trigger_burst_reader_pkg: shared FSM state type and counter-width helpers
// No ports; imported by sync_fifo and trigger_burst_reader.
package trigger_burst_reader_pkg;
   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
   localparam int DROP_W = 16;
   function automatic int cnt_w(input int n);
      return $clog2(n + 1);
   endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: show-ahead FIFO with occupancy count
// clk, rst (async active-low) | push, din: write side | pop, dout, empty: show-ahead read side | count: occupancy
module sync_fifo
   import trigger_burst_reader_pkg::*;
#(
   parameter int W     = 256,
   parameter int DEPTH = 8,
   localparam int CW   = cnt_w(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic [W-1:0]  din,
   input  logic          pop,
   output logic [W-1:0]  dout,
   output logic          empty,
   output logic [CW-1:0] count
);
   localparam int AW = $clog2(DEPTH);
   logic [W-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic wr, rd;
   assign rd = pop && count != '0;
   // a write into a full FIFO is only taken when a read frees the slot in the same cycle
   assign wr = push && (count != CW'(DEPTH) || rd);
   assign empty = count == '0;
   assign dout = empty ? '0 : mem[rd_ptr];
   always_ff @(posedge clk)
      if (wr) mem[wr_ptr] <= din;
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         wr_ptr <= wr_ptr + AW'(wr);
         rd_ptr <= rd_ptr + AW'(rd);
         count  <= count + CW'(wr) - CW'(rd);
      end
endmodule

// File: rtl/trigger_burst_reader.sv
// trigger_burst_reader: on a trigger, burst-read DRAM from timestamp-derived address and stream data to the PC
// clk, rst (async active-low) | trig_valid, trig_ts: trigger in | busy, done, trig_drop_cnt: status
// dram_rd_en/addr/ready: request | dram_rd_data/valid: return | pc_data/valid/ready/last: stream out | proto_err: sticky
module trigger_burst_reader
   import trigger_burst_reader_pkg::*;
#(
   parameter int TS_W       = 16,
   parameter int ADDR_W     = 25,
   parameter int DATA_W     = 256,
   parameter int BURST_LEN  = 11,
   parameter int PRE_TRIG   = 0,
   parameter int FIFO_DEPTH = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              trig_valid,
   input  logic [TS_W-1:0]   trig_ts,
   output logic              busy,
   output logic              done,
   output logic [DROP_W-1:0] trig_drop_cnt,
   output logic              dram_rd_en,
   output logic [ADDR_W-1:0] dram_rd_addr,
   input  logic              dram_rd_ready,
   input  logic [DATA_W-1:0] dram_rd_data,
   input  logic              dram_rd_valid,
   output logic [DATA_W-1:0] pc_data,
   output logic              pc_valid,
   input  logic              pc_ready,
   output logic              pc_last,
   output logic              proto_err
);
   localparam int CW = cnt_w(FIFO_DEPTH);
   localparam int BW = cnt_w(BURST_LEN);
   localparam logic [BW-1:0] LAST = BW'(BURST_LEN - 1);
   state_t state;
   logic [ADDR_W-1:0] addr;
   logic [BW-1:0] req_cnt, beat_cnt;
   logic [CW-1:0] outstanding, fifo_count;
   logic fifo_empty, credit, acc, ret, pop;
   // in-flight reads plus buffered beats never exceed the FIFO, so returns always have room
   assign credit = (CW+1)'(outstanding) + (CW+1)'(fifo_count) < (CW+1)'(FIFO_DEPTH);
   assign dram_rd_en = state == ISSUE && credit;
   assign dram_rd_addr = addr;
   assign acc = dram_rd_en && dram_rd_ready;
   assign ret = dram_rd_valid && outstanding != '0;
   assign pc_valid = !fifo_empty;
   assign pop = pc_valid && pc_ready;
   assign pc_last = pc_valid && beat_cnt == LAST;
   sync_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (ret),
      .din   (dram_rd_data),
      .pop   (pop),
      .dout  (pc_data),
      .empty (fifo_empty),
      .count (fifo_count)
   );
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state         <= IDLE;
         addr          <= '0;
         req_cnt       <= '0;
         beat_cnt      <= '0;
         outstanding   <= '0;
         trig_drop_cnt <= '0;
         busy          <= 1'b0;
         done          <= 1'b0;
         proto_err     <= 1'b0;
      end else begin
         outstanding <= outstanding + CW'(acc) - CW'(ret);
         proto_err   <= proto_err || (dram_rd_valid && outstanding == '0);
         beat_cnt    <= (state == IDLE && trig_valid) ? '0 : beat_cnt + BW'(pop);
         if (trig_valid && state != IDLE && trig_drop_cnt != '1)
            trig_drop_cnt <= trig_drop_cnt + DROP_W'(1);
         case (state)
            IDLE:
               if (trig_valid) begin
                  state   <= ISSUE;
                  busy    <= 1'b1;
                  addr    <= ADDR_W'(trig_ts) - ADDR_W'(PRE_TRIG);
                  req_cnt <= '0;
               end
            ISSUE:
               if (acc) begin
                  addr    <= addr + ADDR_W'(1);
                  req_cnt <= req_cnt + BW'(1);
                  if (req_cnt == LAST) state <= DRAIN;
               end
            DRAIN:
               // the done cycle stays in DRAIN so a trigger arriving with done is still dropped
               if (done) begin
                  done  <= 1'b0;
                  state <= IDLE;
               end else if (pop && pc_last) begin
                  done <= 1'b1;
                  busy <= 1'b0;
               end
            default: state <= IDLE;
         endcase
      end
endmodule

// File: tb/tb_trigger_burst_reader.sv
// tb_trigger_burst_reader: randomized self-checking bench with a transaction-level reference model
module tb_trigger_burst_reader;
   localparam int TS_W = 16, ADDR_W = 25, DATA_W = 256, BURST_LEN = 11, PRE_TRIG = 4, FIFO_DEPTH = 8;
   logic clk = 0, rst;
   logic trig_valid;
   logic [TS_W-1:0] trig_ts;
   logic busy, done, proto_err, dram_rd_en, dram_rd_ready, dram_rd_valid, pc_valid, pc_ready, pc_last;
   logic [15:0] trig_drop_cnt;
   logic [ADDR_W-1:0] dram_rd_addr;
   logic [DATA_W-1:0] dram_rd_data, pc_data;

   trigger_burst_reader #(
      .TS_W(TS_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
      .BURST_LEN(BURST_LEN), .PRE_TRIG(PRE_TRIG), .FIFO_DEPTH(FIFO_DEPTH)
   ) dut (
      .clk(clk), .rst(rst), .trig_valid(trig_valid), .trig_ts(trig_ts),
      .busy(busy), .done(done), .trig_drop_cnt(trig_drop_cnt),
      .dram_rd_en(dram_rd_en), .dram_rd_addr(dram_rd_addr), .dram_rd_ready(dram_rd_ready),
      .dram_rd_data(dram_rd_data), .dram_rd_valid(dram_rd_valid),
      .pc_data(pc_data), .pc_valid(pc_valid), .pc_ready(pc_ready), .pc_last(pc_last),
      .proto_err(proto_err)
   );

   always #5 clk = ~clk;

   int checks = 0, errors = 0;
   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [DATA_W-1:0] data_of(input logic [ADDR_W-1:0] a);
      return {8{7'h35, a}};
   endfunction

   logic [ADDR_W-1:0] exp_addr[$], ret_addr[$], first_addr;
   logic [DATA_W-1:0] exp_data[$];
   int ret_due[$];
   int cyc = 0, outs = 0, fcnt = 0, req_left = 0, beat = 0, acc_cnt = 0, bursts = 0, drop_exp = 0;
   bit m_busy = 0, done_due = 0, exp_proto = 0, spur = 0;
   int pc_mode = 0, dr_mode = 0, lat_mode = 0;

   // DRAM responder, PC sink and reference model, all evaluated on the falling edge
   initial begin
      dram_rd_ready = 0;
      dram_rd_valid = 0;
      dram_rd_data = '0;
      pc_ready = 0;
      forever begin
         @(negedge clk);
         cyc++;
         if (!rst) begin
            exp_addr.delete(); ret_addr.delete(); exp_data.delete(); ret_due.delete();
            outs = 0; fcnt = 0; req_left = 0; beat = 0;
            m_busy = 0; done_due = 0; exp_proto = 0; drop_exp = 0;
            dram_rd_valid = 0;
            check("rst_busy", busy, 0);
            check("rst_done", done, 0);
            check("rst_en", dram_rd_en, 0);
            check("rst_addr", dram_rd_addr, 0);
            check("rst_pc_valid", pc_valid, 0);
            check("rst_pc_last", pc_last, 0);
            check("rst_pc_data", pc_data, 0);
            check("rst_proto", proto_err, 0);
            check("rst_drop", trig_drop_cnt, 0);
            continue;
         end
         check("busy", busy, m_busy && !done_due);
         check("done", done, done_due);
         check("drop_cnt", trig_drop_cnt, 16'(drop_exp));
         check("proto_err", proto_err, exp_proto);
         check("pc_valid", pc_valid, fcnt > 0);
         check("pc_last", pc_last, fcnt > 0 && beat == BURST_LEN - 1);
         check("rd_en", dram_rd_en, m_busy && req_left > 0 && outs + fcnt < FIFO_DEPTH);
         if (dram_rd_en && exp_addr.size() > 0) check("rd_addr", dram_rd_addr, exp_addr[0]);
         if (done_due) begin
            if (trig_valid && drop_exp < 65535) drop_exp++;
            done_due = 0;
            m_busy = 0;
            bursts++;
         end else if (trig_valid) begin
            if (m_busy) begin
               if (drop_exp < 65535) drop_exp++;
            end else begin
               m_busy = 1;
               req_left = BURST_LEN;
               beat = 0;
               acc_cnt = 0;
               for (int k = 0; k < BURST_LEN; k++) begin
                  logic [ADDR_W-1:0] a;
                  a = ADDR_W'(trig_ts) - ADDR_W'(PRE_TRIG) + ADDR_W'(k);
                  exp_addr.push_back(a);
                  exp_data.push_back(data_of(a));
               end
            end
         end
         dram_rd_ready = dr_mode == 0 ? 1'b1 : 1'($urandom_range(0, 1));
         if (dram_rd_en && dram_rd_ready) begin
            if (exp_addr.size() == 0) check("extra_req", 1, 0);
            else void'(exp_addr.pop_front());
            if (acc_cnt == 0) first_addr = dram_rd_addr;
            ret_addr.push_back(dram_rd_addr);
            ret_due.push_back(cyc + (lat_mode == 0 ? 3 : int'($urandom_range(1, 4))));
            acc_cnt++;
            req_left--;
            outs++;
         end
         dram_rd_valid = 0;
         if (ret_due.size() > 0 && ret_due[0] <= cyc) begin
            dram_rd_valid = 1;
            dram_rd_data = data_of(ret_addr.pop_front());
            void'(ret_due.pop_front());
            outs--;
            fcnt++;
         end else if (spur && ret_due.size() == 0 && !m_busy) begin
            dram_rd_valid = 1;
            dram_rd_data = {8{$urandom}};
            exp_proto = 1;
            spur = 0;
         end
         pc_ready = pc_mode == 0 ? 1'b1 : pc_mode == 1 ? 1'b0 : 1'($urandom_range(0, 1));
         if (pc_valid && pc_ready) begin
            if (exp_data.size() == 0) check("extra_beat", 1, 0);
            else check("pc_data", pc_data, exp_data.pop_front());
            fcnt--;
            beat++;
            if (beat == BURST_LEN) done_due = 1;
         end
      end
   end

   task automatic trig(input logic [TS_W-1:0] ts);
      @(posedge clk); #1;
      trig_valid = 1;
      trig_ts = ts;
      @(posedge clk); #1;
      trig_valid = 0;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 3000; i++) begin
         @(posedge clk); #1;
         if (!m_busy) return;
      end
      check("idle_timeout", 0, 1);
   endtask

   int b0;
   initial begin
      rst = 0;
      trig_valid = 0;
      trig_ts = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1;
      trig(16'h0100);
      wait_idle();
      check("t1_bursts", bursts, 1);
      check("t1_first_addr", first_addr, 25'h00000FC);
      trig(16'h0002);
      wait_idle();
      check("t2_first_addr", first_addr, 25'h1FFFFFE);
      check("t2_count", acc_cnt, 11);
      pc_mode = 1;
      trig(16'h1234);
      repeat (60) @(posedge clk);
      #1;
      check("stall_accepted", acc_cnt, 8);
      check("stall_en", dram_rd_en, 0);
      pc_mode = 0;
      wait_idle();
      check("stall_total", acc_cnt, 11);
      dr_mode = 1;
      lat_mode = 1;
      pc_mode = 2;
      for (int i = 0; i < 6; i++) begin
         trig(16'($urandom));
         wait_idle();
      end
      dr_mode = 0;
      lat_mode = 0;
      pc_mode = 0;
      b0 = bursts;
      trig(16'h0400);
      repeat (3) begin
         repeat (2) @(posedge clk);
         #1 trig_valid = 1;
         @(posedge clk);
         #1 trig_valid = 0;
      end
      for (int i = 0; i < 500; i++) begin
         @(posedge clk); #1;
         if (done) break;
      end
      check("t5_done_seen", done, 1);
      trig_valid = 1;
      @(posedge clk);
      #1 trig_valid = 0;
      repeat (5) @(posedge clk);
      #1;
      check("t5_drop4", trig_drop_cnt, 4);
      check("t5_one_burst", bursts - b0, 1);
      check("t5_idle", busy, 0);
      trig(16'h0500);
      wait_idle();
      check("t5_fresh_burst", bursts - b0, 2);
      spur = 1;
      repeat (4) @(posedge clk);
      #1;
      check("spur_proto", proto_err, 1);
      check("spur_pc_valid", pc_valid, 0);
      trig(16'h0700);
      repeat (4) @(posedge clk);
      #3 rst = 0;
      #1;
      check("arst_busy", busy, 0);
      check("arst_en", dram_rd_en, 0);
      check("arst_pc_valid", pc_valid, 0);
      check("arst_proto", proto_err, 0);
      check("arst_drop", trig_drop_cnt, 0);
      b0 = bursts;
      repeat (3) @(posedge clk);
      #1 rst = 1;
      repeat (30) @(posedge clk);
      #1;
      check("arst_no_done", bursts, b0);
      trig(16'h0800);
      wait_idle();
      check("post_rst_burst", bursts - b0, 1);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
